// File: rtl/fighter_pkg.sv
// -----------------------------------------------------------------------------
// fighter_pkg
// Shared constants and types for the fighter gameplay blocks: player body and
// attack hitbox geometry, health range, coordinate/edge widths and the
// hit-resolution FSM state encoding.
// -----------------------------------------------------------------------------
package fighter_pkg;

    localparam int BOX_W      = 60;   // player body width in pixels
    localparam int BOX_H      = 60;   // player body height in pixels
    localparam int ATK1_W     = 30;   // attack hitbox width
    localparam int ATK1_H     = 60;   // attack hitbox height
    localparam int MAX_HEALTH = 100;  // defender health after reset

    localparam int COORD_W  = 10;     // screen coordinate width
    localparam int EDGE_W   = 11;     // one extra bit so edge sums never wrap
    localparam int HEALTH_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SPENT = 2'd2,
        KO    = 2'd3
    } fsm_state_t;

endpackage

// File: rtl/box_overlap.sv
// -----------------------------------------------------------------------------
// box_overlap
// Combinational intersection test of two axis-aligned boxes, each given as
// half-open intervals [lo, hi) on both axes. Boxes that only share an edge do
// not overlap; an empty interval (lo == hi) never overlaps anything.
//
// Ports
//   a_x_lo/a_x_hi/a_y_lo/a_y_hi : box A edges (EDGE_W bits, unsigned)
//   b_x_lo/b_x_hi/b_y_lo/b_y_hi : box B edges (EDGE_W bits, unsigned)
//   overlap                     : 1 when the boxes strictly intersect
// -----------------------------------------------------------------------------
module box_overlap
    import fighter_pkg::*;
(
    input  logic [EDGE_W-1:0] a_x_lo,
    input  logic [EDGE_W-1:0] a_x_hi,
    input  logic [EDGE_W-1:0] a_y_lo,
    input  logic [EDGE_W-1:0] a_y_hi,
    input  logic [EDGE_W-1:0] b_x_lo,
    input  logic [EDGE_W-1:0] b_x_hi,
    input  logic [EDGE_W-1:0] b_y_lo,
    input  logic [EDGE_W-1:0] b_y_hi,
    output logic              overlap
);

    logic x_hit;
    logic y_hit;

    always_comb begin
        x_hit   = (a_x_lo < b_x_hi) && (b_x_lo < a_x_hi);
        y_hit   = (a_y_lo < b_y_hi) && (b_y_lo < a_y_hi);
        overlap = x_hit && y_hit;
    end

endmodule

// File: rtl/hit_resolver.sv
// -----------------------------------------------------------------------------
// hit_resolver
// Decides when an attacker's hitbox lands on the defender. One hit is allowed
// per continuous attack_active interval; a landed hit removes DAMAGE health,
// starts a hitstun (invulnerability) window of HITSTUN_FRAMES frames and
// drops into a sticky KO state once health reaches 0. All state advances only
// on frame ticks (SCEN), except hit_pulse which is a single-clk strobe.
//
// Ports
//   clk            : pixel clock
//   reset          : asynchronous active-high reset
//   SCEN           : one-clk frame-tick enable
//   hit_enable     : gates all hit evaluation
//   attack_active  : attacker hitbox is live
//   facing_right   : attacker facing direction
//   atk_x/atk_y    : attacker body top-left corner
//   def_x/def_y    : defender body top-left corner
//   hit_pulse      : one-clk pulse per landed hit
//   def_health     : defender health, 0..MAX_HEALTH
//   hitstun        : defender invulnerable
//   ko             : defender health reached 0 (sticky until reset)
// -----------------------------------------------------------------------------
module hit_resolver #(
    parameter int BOX_W          = fighter_pkg::BOX_W,
    parameter int BOX_H          = fighter_pkg::BOX_H,
    parameter int ATK1_W         = fighter_pkg::ATK1_W,
    parameter int ATK1_H         = fighter_pkg::ATK1_H,
    parameter int DAMAGE         = 10,
    parameter int MAX_HEALTH     = fighter_pkg::MAX_HEALTH,
    parameter int HITSTUN_FRAMES = 12
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               SCEN,
    input  logic                               hit_enable,
    input  logic                               attack_active,
    input  logic                               facing_right,
    input  logic [fighter_pkg::COORD_W-1:0]    atk_x,
    input  logic [fighter_pkg::COORD_W-1:0]    atk_y,
    input  logic [fighter_pkg::COORD_W-1:0]    def_x,
    input  logic [fighter_pkg::COORD_W-1:0]    def_y,
    output logic                               hit_pulse,
    output logic [fighter_pkg::HEALTH_W-1:0]   def_health,
    output logic                               hitstun,
    output logic                               ko
);

    import fighter_pkg::*;

    localparam int CNT_W = (HITSTUN_FRAMES < 1) ? 1 : $clog2(HITSTUN_FRAMES + 1);

    localparam logic [EDGE_W-1:0]   BOX_W_E   = EDGE_W'(BOX_W);
    localparam logic [EDGE_W-1:0]   BOX_H_E   = EDGE_W'(BOX_H);
    localparam logic [EDGE_W-1:0]   ATK1_W_E  = EDGE_W'(ATK1_W);
    localparam logic [EDGE_W-1:0]   ATK1_H_E  = EDGE_W'(ATK1_H);
    localparam logic [HEALTH_W-1:0] DAMAGE_H  = HEALTH_W'(DAMAGE);
    localparam logic [HEALTH_W-1:0] MAX_HP_H  = HEALTH_W'(MAX_HEALTH);
    localparam logic [CNT_W-1:0]    STUN_LOAD = CNT_W'(HITSTUN_FRAMES);

    // Health never wraps below zero.
    function automatic logic [HEALTH_W-1:0] sat_sub_health(
        input logic [HEALTH_W-1:0] health,
        input logic [HEALTH_W-1:0] dmg
    );
        return (health > dmg) ? (health - dmg) : '0;
    endfunction

    // ---------------- hitbox / hurtbox edges ----------------
    logic [EDGE_W-1:0] atk_x_e, atk_y_e, def_x_e, def_y_e;
    logic [EDGE_W-1:0] right_x_lo, right_x_hi;
    logic [EDGE_W-1:0] left_x_lo, left_x_hi;
    logic [EDGE_W-1:0] hit_y_lo, hit_y_hi;
    logic [EDGE_W-1:0] hurt_x_hi, hurt_y_hi;
    logic              overlap_right, overlap_left, overlap;

    always_comb begin
        atk_x_e    = {1'b0, atk_x};
        atk_y_e    = {1'b0, atk_y};
        def_x_e    = {1'b0, def_x};
        def_y_e    = {1'b0, def_y};
        right_x_lo = atk_x_e + BOX_W_E;
        right_x_hi = right_x_lo + ATK1_W_E;
        // Left-facing hitbox is clamped at the screen edge instead of wrapping.
        left_x_lo  = (atk_x_e < ATK1_W_E) ? '0 : (atk_x_e - ATK1_W_E);
        left_x_hi  = atk_x_e;
        hit_y_lo   = atk_y_e;
        hit_y_hi   = atk_y_e + ATK1_H_E;
        hurt_x_hi  = def_x_e + BOX_W_E;
        hurt_y_hi  = def_y_e + BOX_H_E;
    end

    box_overlap u_overlap_right (
        .a_x_lo  (right_x_lo),
        .a_x_hi  (right_x_hi),
        .a_y_lo  (hit_y_lo),
        .a_y_hi  (hit_y_hi),
        .b_x_lo  (def_x_e),
        .b_x_hi  (hurt_x_hi),
        .b_y_lo  (def_y_e),
        .b_y_hi  (hurt_y_hi),
        .overlap (overlap_right)
    );

    box_overlap u_overlap_left (
        .a_x_lo  (left_x_lo),
        .a_x_hi  (left_x_hi),
        .a_y_lo  (hit_y_lo),
        .a_y_hi  (hit_y_hi),
        .b_x_lo  (def_x_e),
        .b_x_hi  (hurt_x_hi),
        .b_y_lo  (def_y_e),
        .b_y_hi  (hurt_y_hi),
        .overlap (overlap_left)
    );

    assign overlap = facing_right ? overlap_right : overlap_left;

    // ---------------- FSM, health and hitstun ----------------
    fsm_state_t            state_q, state_d;
    logic [HEALTH_W-1:0]   health_q, health_d;
    logic [CNT_W-1:0]      stun_cnt_q, stun_cnt_d;
    logic                  hit_pulse_q, hit_pulse_d;
    logic                  stun_active;

    assign stun_active = (stun_cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        health_d    = health_q;
        stun_cnt_d  = stun_cnt_q;
        hit_pulse_d = 1'b0;   // strobe clears on the clk after it was set

        if (SCEN) begin
            if (stun_active) begin
                stun_cnt_d = stun_cnt_q - CNT_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (attack_active) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (!attack_active) begin
                        state_d = IDLE;
                    end else if (hit_enable && overlap && !stun_active) begin
                        hit_pulse_d = 1'b1;
                        health_d    = sat_sub_health(health_q, DAMAGE_H);
                        // Load overrides the decrement on the hit tick.
                        stun_cnt_d  = STUN_LOAD;
                        state_d     = (health_d == '0) ? KO : SPENT;
                    end
                end
                SPENT: begin
                    if (!attack_active) begin
                        state_d = IDLE;
                    end
                end
                KO: begin
                    state_d = KO;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            health_q    <= MAX_HP_H;
            stun_cnt_q  <= '0;
            hit_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            health_q    <= health_d;
            stun_cnt_q  <= stun_cnt_d;
            hit_pulse_q <= hit_pulse_d;
        end
    end

    assign hit_pulse  = hit_pulse_q;
    assign def_health = health_q;
    assign hitstun    = stun_active;
    assign ko         = (state_q == KO);

endmodule

// File: tb/tb_hit_resolver.sv
// -----------------------------------------------------------------------------
// tb_hit_resolver
// Directed scenarios for hit_resolver. Stimulus pushes the expected
// {ko, def_health} of every hit it intends to land into a queue; a monitor pops
// and compares whenever the DUT raises hit_pulse.
// -----------------------------------------------------------------------------
module tb_hit_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCEN;
    logic       hit_enable;
    logic       attack_active;
    logic       facing_right;
    logic [9:0] atk_x, atk_y, def_x, def_y;
    logic       hit_pulse;
    logic [6:0] def_health;
    logic       hitstun;
    logic       ko;

    int         checks = 0;
    int         errors = 0;
    int         stun_frames;
    logic [7:0] exp_q[$];
    logic [7:0] exp_e;

    always #5 clk = ~clk;

    hit_resolver dut (
        .clk           (clk),
        .reset         (reset),
        .SCEN          (SCEN),
        .hit_enable    (hit_enable),
        .attack_active (attack_active),
        .facing_right  (facing_right),
        .atk_x         (atk_x),
        .atk_y         (atk_y),
        .def_x         (def_x),
        .def_y         (def_y),
        .hit_pulse     (hit_pulse),
        .def_health    (def_health),
        .hitstun       (hitstun),
        .ko            (ko)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every hit_pulse must match the oldest expected hit.
    always @(negedge clk) begin
        if (!reset && hit_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit: hit_pulse=1 (health=%0d) but want no hit", def_health);
            end else begin
                exp_e = exp_q.pop_front();
                check("hit_health", int'(def_health), int'(exp_e[6:0]));
                check("hit_ko", int'(ko), int'(exp_e[7]));
            end
        end
    end

    task automatic expect_hit(input int health, input bit k);
        exp_q.push_back({k, 7'(health)});
    endtask

    task automatic drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected hit(s) not seen, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // One frame tick: SCEN high for a single clk, then a few quiet clks.
    task automatic tick();
        @(negedge clk) SCEN = 1'b1;
        @(negedge clk) SCEN = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic swing(input int on_frames, input int idle_frames);
        attack_active = 1'b1;
        repeat (on_frames) tick();
        attack_active = 1'b0;
        repeat (idle_frames) tick();
    endtask

    task automatic set_pos(input int ax, input int ay, input int dx, input int dy, input bit fr);
        atk_x        = 10'(ax);
        atk_y        = 10'(ay);
        def_x        = 10'(dx);
        def_y        = 10'(dy);
        facing_right = fr;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        SCEN          = 1'b0;
        hit_enable    = 1'b1;
        attack_active = 1'b0;
        set_pos(0, 0, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        check("reset_health", int'(def_health), 100);
        check("reset_ko", int'(ko), 0);
        check("reset_hitstun", int'(hitstun), 0);
        check("reset_pulse", int'(hit_pulse), 0);
        reset = 1'b0;

        // Scenario 1: facing right, hurtbox overlaps, attack held 10 frames.
        set_pos(200, 100, 265, 100, 1'b1);
        expect_hit(90, 1'b0);
        attack_active = 1'b1;
        stun_frames   = 0;
        for (int f = 0; f < 24; f++) begin
            if (f == 10) attack_active = 1'b0;
            tick();
            if (hitstun) stun_frames++;
        end
        drained("s1_hit");
        check("s1_health", int'(def_health), 90);
        check("s1_stun_frames", stun_frames, 12);

        // Hold well past hitstun: still only one hit for the interval.
        expect_hit(80, 1'b0);
        swing(25, 2);
        drained("s1_long_hold");
        check("s1_long_health", int'(def_health), 80);

        // hit_enable low keeps the FSM armed but lands nothing until raised.
        hit_enable    = 1'b0;
        attack_active = 1'b1;
        repeat (4) tick();
        check("s1_disabled_health", int'(def_health), 80);
        expect_hit(70, 1'b0);
        hit_enable = 1'b1;
        tick();
        attack_active = 1'b0;
        tick();
        drained("s1_enable_late");
        repeat (14) tick();

        // Attack released on the tick it would have landed.
        swing(1, 2);
        check("s1_release_health", int'(def_health), 70);

        // Scenario 2: facing left.
        do_reset();
        check("s2_reset_health", int'(def_health), 100);
        set_pos(200, 100, 265, 100, 1'b0);
        swing(5, 2);
        check("s2_wrong_side", int'(def_health), 100);
        set_pos(300, 100, 250, 100, 1'b0);
        expect_hit(90, 1'b0);
        swing(3, 14);
        drained("s2_left_hit");
        // Low bound clamped to 0: hitbox [0,10).
        set_pos(10, 100, 0, 100, 1'b0);
        expect_hit(80, 1'b0);
        swing(3, 14);
        drained("s2_clamp_hit");
        set_pos(10, 100, 10, 100, 1'b0);
        swing(3, 2);
        check("s2_clamp_touch", int'(def_health), 80);

        // Scenario 3: touching edges never count.
        do_reset();
        set_pos(200, 100, 290, 100, 1'b1);
        swing(3, 2);
        check("s3_x_touch", int'(def_health), 100);
        set_pos(200, 100, 289, 100, 1'b1);
        expect_hit(90, 1'b0);
        swing(3, 14);
        drained("s3_x_inside");
        set_pos(200, 100, 265, 160, 1'b1);
        swing(3, 2);
        check("s3_y_touch", int'(def_health), 90);
        set_pos(200, 100, 265, 159, 1'b1);
        expect_hit(80, 1'b0);
        swing(3, 14);
        drained("s3_y_inside");
        // Hitbox [1060,1090) exists only with 11-bit edges.
        set_pos(1000, 100, 1023, 100, 1'b1);
        expect_hit(70, 1'b0);
        swing(3, 14);
        drained("s3_no_wrap");
        check("s3_health", int'(def_health), 70);

        // Scenario 4: ten spaced hits to KO, then KO absorbs a further attack.
        do_reset();
        set_pos(200, 100, 265, 100, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            expect_hit(100 - 10 * k, k == 10);
            swing(3, 14);
        end
        drained("s4_ten_hits");
        check("s4_health", int'(def_health), 0);
        check("s4_ko", int'(ko), 1);
        swing(3, 14);
        check("s4_after_ko_health", int'(def_health), 0);
        check("s4_after_ko_ko", int'(ko), 1);

        // Scenario 6: asynchronous reset between ticks while in KO.
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("s6_ko_reset_health", int'(def_health), 100);
        check("s6_ko_reset_ko", int'(ko), 0);
        check("s6_ko_reset_pulse", int'(hit_pulse), 0);
        @(negedge clk) reset = 1'b0;
        // Reset mid-attack during hitstun, then the held swing is eligible again.
        expect_hit(90, 1'b0);
        attack_active = 1'b1;
        tick();
        tick();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("s6_mid_reset_hitstun", int'(hitstun), 0);
        check("s6_mid_reset_health", int'(def_health), 100);
        @(negedge clk) reset = 1'b0;
        expect_hit(90, 1'b0);
        tick();
        tick();
        attack_active = 1'b0;
        tick();
        drained("s6_after_reset");
        check("s6_health", int'(def_health), 90);

        // Scenario 5: second swing begun during hitstun lands once it clears.
        do_reset();
        set_pos(200, 100, 265, 100, 1'b1);
        expect_hit(90, 1'b0);
        swing(3, 1);
        attack_active = 1'b1;
        tick();
        for (int i = 0; i < 30 && hitstun; i++) tick();
        check("s5_stun_cleared", int'(hitstun), 0);
        check("s5_no_hit_in_stun", int'(def_health), 90);
        expect_hit(80, 1'b0);
        tick();
        repeat (3) tick();
        attack_active = 1'b0;
        tick();
        drained("s5_late_hit");
        check("s5_health", int'(def_health), 80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hit_resolver.md
HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
- REQ-001: The block SHALL have these parameters, one per line as name, default, meaning:
  - BOX_W, 60, player body width in pixels.
  - BOX_H, 60, player body height in pixels.
  - ATK1_W, 30, attack hitbox width.
  - ATK1_H, 60, attack hitbox height.
  - DAMAGE, 10, health removed per hit.
  - MAX_HEALTH, 100, defender health after reset.
  - HITSTUN_FRAMES, 12, invulnerability length in frames.
- REQ-002: The block SHALL have these ports, one per line as name, direction, width, meaning:
  - clk, input, 1, the single clock, pixel clock domain.
  - reset, input, 1, asynchronous active-high reset.
  - SCEN, input, 1, one-clk frame-tick enable.
  - hit_enable, input, 1, gates all hit evaluation.
  - attack_active, input, 1, attacker hitbox is live.
  - facing_right, input, 1, attacker facing direction.
  - atk_x, input, 10, attacker box left edge.
  - atk_y, input, 10, attacker box top edge.
  - def_x, input, 10, defender box left edge.
  - def_y, input, 10, defender box top edge.
  - hit_pulse, output, 1, one-clk pulse per landed hit.
  - def_health, output, 7, defender health, range 0..MAX_HEALTH.
  - hitstun, output, 1, defender is in hitstun and invulnerable.
  - ko, output, 1, defender health reached 0 (sticky).

Function
- REQ-003: The hitbox x-range SHALL be [atk_x+BOX_W, atk_x+BOX_W+ATK1_W) when facing_right=1.
- REQ-004: When facing_right=0, the hitbox x-range SHALL be [atk_x-ATK1_W, atk_x), with the low bound clamped to 0 when atk_x<ATK1_W.
- REQ-005: The hitbox y-range SHALL be [atk_y, atk_y+ATK1_H).
- REQ-006: The defender hurtbox SHALL be [def_x, def_x+BOX_W) x [def_y, def_y+BOX_H).
- REQ-007: All edge sums SHALL use 11-bit unsigned arithmetic, with no wrap.
- REQ-008: Overlap SHALL be true only for strict half-open interval intersection on both axes; edges that merely touch SHALL NOT count.
- REQ-009: All state SHALL update only on clk edges where SCEN=1, except that hit_pulse deasserts on the next clk edge.
- REQ-010: The FSM SHALL have the states IDLE, ARMED, SPENT and KO.
- REQ-011: From IDLE, on SCEN with attack_active=1, the FSM SHALL go to ARMED.
- REQ-012: From ARMED, on SCEN with attack_active=1, hit_enable=1, overlap=1 and hitstun=0, the block SHALL:
  - go to SPENT;
  - assert hit_pulse;
  - subtract DAMAGE from def_health;
  - load the hitstun counter with HITSTUN_FRAMES.
- REQ-013: From ARMED or SPENT, on SCEN with attack_active=0, the FSM SHALL go to IDLE.
- REQ-014: Exactly one hit SHALL land per continuous attack_active interval.
- REQ-015: def_health SHALL saturate at 0 and never underflow.
- REQ-016: When def_health becomes 0, the FSM SHALL enter KO on the same edge, with ko=1.
- REQ-017: KO SHALL be absorbing until reset.
- REQ-018: hit_pulse SHALL still assert on the KO-causing hit.
- REQ-019: The hitstun counter SHALL decrement on each SCEN while nonzero.
- REQ-020: hitstun SHALL equal (counter != 0).
- REQ-021: The counter SHALL load on the hit edge and SHALL NOT decrement on that same edge.
- REQ-022: When attack_active falls on the same SCEN that overlap is detected, no hit SHALL land.
- REQ-023: When hit_enable=0, the FSM SHALL still track IDLE/ARMED/SPENT, but no hit SHALL land.
- REQ-024: hit_pulse SHALL be high for exactly one clk cycle, the cycle after the qualifying SCEN edge.

Reset
- REQ-025: Asserting reset SHALL immediately, without waiting for clk, set:
  - state=IDLE;
  - def_health=MAX_HEALTH;
  - hitstun counter=0;
  - hit_pulse=0, hitstun=0, ko=0.
- REQ-026: Reset asserted mid-attack or in KO SHALL discard all progress.
- REQ-027: After reset, the first attack_active interval SHALL be eligible to hit.

Structure
- REQ-028: BOX_W, BOX_H, ATK1_W, ATK1_H, MAX_HEALTH and the FSM state encoding SHALL live in the shared package fighter_pkg.
- REQ-029: The overlap test SHALL be a combinational sub-module named box_overlap, reused for both hitbox orientations.
- REQ-030: The implementation SHALL fit in 120-400 lines of RTL.

Verification
- REQ-031: Scenario 1: atk_x=200, def_x=265, facing_right=1, y equal; attack_active held for 10 frames -> one hit_pulse, def_health=90, hitstun high for 12 frames.
- REQ-032: Scenario 2: same positions, facing_right=0 -> no hit; then atk_x=300, def_x=250 with facing left -> hit lands.
- REQ-033: Scenario 3: def_x=290 with atk_x=200 facing right (touching edge) -> no hit; def_x=289 -> hit.
- REQ-034: Scenario 4: ten spaced attacks, each landing after hitstun expires -> def_health steps 100..0, ko=1 on the tenth; an eleventh attack produces no hit_pulse and health stays 0.
- REQ-035: Scenario 5: a second attack started while hitstun=1 -> no hit; the same swing still active after hitstun clears -> hit lands once.
- REQ-036: Scenario 6: reset asserted between SCEN ticks while in KO -> outputs return to reset values before the next clk edge.
